// File: rtl/core_wb_sched.sv
// Writeback scheduler for the RV32 integer register file: register scoreboard with
// issue hazard stalls, ALU/LSU arbitration for the single write port, and a registered write stage.
module core_wb_sched #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic [4:0]      iss_rd,
    input  logic            iss_wreg,
    output logic            iss_stall,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_wreg,
    output logic [4:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data,
    output logic [31:0]     busy,
    output logic            err
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0]   starve;
    logic [SW-1:0]   starve_nxt;
    logic            pri_alu;
    logic            alu_fire;
    logic            lsu_fire;
    logic            fire;
    logic [4:0]      fire_rd;
    logic [XLEN-1:0] fire_data;
    logic            hz_rs1;
    logic            hz_rs2;
    logic            hz_rd;
    logic            iss_accept;
    logic [31:0]     busy_set;
    logic [31:0]     busy_clr;
    logic [31:0]     busy_nxt;
    logic            err_hit;

    // Issue hazards: x0 is never a hazard, so its busy bit is simply ignored here.
    assign hz_rs1     = (iss_rs1 != 5'd0) & busy[iss_rs1];
    assign hz_rs2     = (iss_rs2 != 5'd0) & busy[iss_rs2];
    assign hz_rd      = iss_wreg & (iss_rd != 5'd0) & busy[iss_rd];
    assign iss_stall  = iss_valid & (hz_rs1 | hz_rs2 | hz_rd);
    assign iss_accept = iss_valid & ~iss_stall;

    // LSU normally wins; a starved ALU takes the port once the counter saturates.
    assign pri_alu   = (starve == STARVE_LIM);
    assign lsu_ready = ~rst & ~(alu_valid & pri_alu);
    assign alu_ready = ~rst & (~lsu_valid | pri_alu);
    assign alu_fire  = alu_valid & alu_ready;
    assign lsu_fire  = lsu_valid & lsu_ready;
    assign fire      = alu_fire | lsu_fire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fire_rd   = lsu_rd;
        fire_data = lsu_data;
        if (alu_fire) begin
            fire_rd   = alu_rd;
            fire_data = alu_data;
        end
    end

    always_comb begin
        starve_nxt = '0;
        if (alu_valid & ~alu_ready) begin
            starve_nxt = (starve == STARVE_LIM) ? starve : starve + SW'(1);
        end
    end

    // Clear follows the register-file write; a same-register set in the same cycle wins.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_accept & iss_wreg) busy_set[iss_rd] = 1'b1;
        if (rf_wreg) busy_clr[rf_rd_addr] = 1'b1;
        busy_nxt    = (busy & ~busy_clr) | busy_set;
        busy_nxt[0] = 1'b0;
    end

    assign err_hit = fire & (fire_rd != 5'd0)
                   & (~busy[fire_rd] | (rf_wreg & (rf_rd_addr == fire_rd)));

    // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            starve     <= '0;
            err        <= 1'b0;
            rf_wreg    <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
        end else begin
            busy    <= busy_nxt;
            starve  <= starve_nxt;
            err     <= err | err_hit;
            rf_wreg <= fire & (fire_rd != 5'd0);
            if (fire) begin
                rf_rd_addr <= fire_rd;
                rf_rd_data <= fire_data;
            end
        end
    end

endmodule

// File: tb/tb_core_wb_sched.sv
// Self-checking bench for core_wb_sched: scripted cycle table plus hand sequences for reset,
// protocol errors and mid-operation reset; write-port results checked through a scoreboard queue.
module tb_core_wb_sched;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    logic            clk;
    logic            rst;
    logic            iss_valid;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic [4:0]      iss_rd;
    logic            iss_wreg;
    logic            iss_stall;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            rf_wreg;
    logic [4:0]      rf_rd_addr;
    logic [XLEN-1:0] rf_rd_data;
    logic [31:0]     busy;
    logic            err;

    core_wb_sched #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_wreg(iss_wreg), .iss_stall(iss_stall),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wreg(rf_wreg), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wreg;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        e_stall;
        logic        e_ardy;
        logic        e_lrdy;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic        wreg;
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_exp_t;

    vec_t        vq[$];
    rf_exp_t     sb_q[$];
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    int          n_checks;
    int          n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wreg,
                           input logic av, input logic [4:0] ard, input logic [31:0] adat,
                           input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                           input logic es, input logic ea, input logic el, input logic [31:0] eb);
        vec_t v;
        v = '{iv, rs1, rs2, rd, wreg, av, ard, adat, lv, lrd, ldat, es, ea, el, eb};
        vq.push_back(v);
    endtask

    // Expected write-stage contents after the coming edge.
    task automatic sb_push(input logic fire, input logic [4:0] rd, input logic [31:0] d);
        rf_exp_t e;
        if (fire) begin
            last_addr = rd;
            last_data = d;
        end
        e.wreg = fire & (rd != 5'd0);
        e.addr = last_addr;
        e.data = last_data;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        rf_exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rf_wreg", {31'd0, rf_wreg}, {31'd0, e.wreg});
            check("rf_rd_addr", {27'd0, rf_rd_addr}, {27'd0, e.addr});
            check("rf_rd_data", rf_rd_data, e.data);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0; iss_wreg = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
        last_addr = 5'd0;
        last_data = '0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_addr = 5'd0;
        last_data = '0;
        idle();

        // Reset: readies held low while rst is high even with both requests pending.
        rst = 1'b1;
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("alu_ready_in_rst", {31'd0, alu_ready}, 32'd0);
        check("lsu_ready_in_rst", {31'd0, lsu_ready}, 32'd0);
        idle();
        do_reset();
        check("rst_busy", busy, 32'd0);
        check("rst_rf_wreg", {31'd0, rf_wreg}, 32'd0);
        check("rst_rf_addr", {27'd0, rf_rd_addr}, 32'd0);
        check("rst_rf_data", rf_rd_data, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        //      iv rs1   rs2   rd     w   av ard   adat          lv lrd   ldat          st a  l  busy
        add_vec(1, 5'd0, 5'd0, 5'd5,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h020);
        add_vec(1, 5'd5, 5'd0, 5'd6,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 1, 1, 32'h020);
        add_vec(1, 5'd5, 5'd0, 5'd6,  1,  1, 5'd5, 32'h1234,     0, 5'd0, 32'h0,        1, 1, 1, 32'h020);
        add_vec(1, 5'd5, 5'd0, 5'd6,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 1, 1, 32'h000);
        add_vec(1, 5'd5, 5'd0, 5'd6,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h040);
        add_vec(1, 5'd0, 5'd0, 5'd3,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h048);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  0, 5'd0, 32'h0,        1, 5'd3, 32'hAAAA0003, 0, 0, 1, 32'h048);
        add_vec(1, 5'd0, 5'd0, 5'd7,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h0C0);
        add_vec(1, 5'd0, 5'd0, 5'd0,  1,  0, 5'd0, 32'h0,        1, 5'd0, 32'h55,       0, 0, 1, 32'h0C0);
        add_vec(1, 5'd0, 5'd0, 5'd9,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h2C0);
        add_vec(1, 5'd0, 5'd0, 5'd9,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 1, 1, 32'h2C0);
        add_vec(1, 5'd0, 5'd7, 5'd0,  0,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 1, 1, 32'h2C0);
        add_vec(0, 5'd7, 5'd9, 5'd9,  1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h2C0);
        add_vec(1, 5'd0, 5'd0, 5'd10, 1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h6C0);
        add_vec(1, 5'd0, 5'd0, 5'd11, 1,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'hEC0);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  1, 5'd6, 32'h6666,     1, 5'd7, 32'h7,        0, 0, 1, 32'hEC0);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  1, 5'd6, 32'h6666,     1, 5'd9, 32'h9,        0, 0, 1, 32'hE40);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  1, 5'd6, 32'h6666,     1, 5'd10, 32'hA,       0, 0, 1, 32'hC40);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  1, 5'd6, 32'h6666,     1, 5'd11, 32'hB,       0, 0, 1, 32'h840);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  1, 5'd6, 32'h6666,     1, 5'd12, 32'hC,       0, 1, 0, 32'h040);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  1, 5'd0, 32'hDEAD,     1, 5'd0, 32'hBEEF,     0, 0, 1, 32'h000);
        add_vec(0, 5'd0, 5'd0, 5'd0,  0,  0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 1, 32'h000);

        foreach (vq[i]) begin
            vec_t v;
            logic afire;
            logic lfire;
            v = vq[i];
            iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd; iss_wreg = v.wreg;
            alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
            lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
            @(negedge clk);
            check($sformatf("v%0d_iss_stall", i), {31'd0, iss_stall}, {31'd0, v.e_stall});
            check($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, v.e_ardy});
            check($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, v.e_lrdy});
            afire = v.av & v.e_ardy;
            lfire = v.lv & v.e_lrdy;
            sb_push(afire | lfire, afire ? v.ard : v.lrd, afire ? v.adat : v.ldat);
            tick();
            check($sformatf("v%0d_busy", i), busy, v.e_busy);
        end
        check("table_err_clear", {31'd0, err}, 32'd0);

        // Protocol error: write to a register with no pending write; sticky until reset.
        idle();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0DE000C;
        @(negedge clk);
        check("perr_alu_ready", {31'd0, alu_ready}, 32'd1);
        sb_push(1'b1, 5'd12, 32'hC0DE000C);
        tick();
        check("perr_err_set", {31'd0, err}, 32'd1);
        idle();
        for (int k = 0; k < 4; k++) begin
            sb_push(1'b0, 5'd0, '0);
            tick();
        end
        check("perr_err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        check("perr_err_cleared", {31'd0, err}, 32'd0);

        // Second write to a register already being written by the output stage.
        iss_valid = 1'b1; iss_rd = 5'd14; iss_wreg = 1'b1;
        sb_push(1'b0, 5'd0, '0);
        tick();
        check("dbl_busy14", busy, 32'h4000);
        idle();
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h1;
        sb_push(1'b1, 5'd14, 32'h1);
        tick();
        check("dbl_first_ok", {31'd0, err}, 32'd0);
        alu_data = 32'h2;
        sb_push(1'b1, 5'd14, 32'h2);
        tick();
        check("dbl_err_set", {31'd0, err}, 32'd1);
        idle();
        sb_push(1'b0, 5'd0, '0);
        tick();

        // Reset mid-operation drops the pending write and the in-flight fire.
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd13; iss_wreg = 1'b1;
        sb_push(1'b0, 5'd0, '0);
        tick();
        check("mid_busy13", busy, 32'h2000);
        idle();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
        @(negedge clk);
        check("mid_alu_ready", {31'd0, alu_ready}, 32'd0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        idle();
        check("mid_busy", busy, 32'd0);
        check("mid_rf_wreg", {31'd0, rf_wreg}, 32'd0);
        check("mid_err", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
